// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV64 funct3 encodings, FSM states
// and the access-size helper.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  // Access size in bytes: 1, 2, 4 or 8.
  function automatic logic [3:0] access_size(input logic [2:0] funct3);
    return 4'd1 << funct3[1:0];
  endfunction

endpackage

// File: rtl/load_store_unit_load_align_extend.sv
// Combinational load path: moves the addressed bytes of a bus word down to
// bit 0 and sign- or zero-extends them to the full register width.
module load_align_extend
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    data    = shifted;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_LH:   data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_LW:   data = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      F3_LD:   data = shifted;
      F3_LBU:  data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      F3_LWU:  data = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV64 load/store unit: one request at a time, byte-lane alignment and
// strobes, req/ack data bus with wait states, fault reporting to the core.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int STRB_WIDTH = XLEN / 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  lsu_valid,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [XLEN-1:0]       address,
  input  logic [XLEN-1:0]       store_data,
  output logic                  lsu_busy,
  output logic                  lsu_done,
  output logic                  lsu_error,
  output logic [XLEN-1:0]       load_data,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [XLEN-1:0]       bus_addr,
  output logic [XLEN-1:0]       bus_wdata,
  output logic [STRB_WIDTH-1:0] bus_wstrb,
  input  logic                  bus_ack,
  input  logic [XLEN-1:0]       bus_rdata,
  output state_e                state
);

  // Handshakes: the core's request is taken only in IDLE when lsu_valid and a
  // read/write flag are set. On the bus, req and all bus fields stay stable
  // from the accept edge until the edge that samples bus_ack=1; ack is
  // ignored in every other state.

  state_e                state_next;
  logic                  accept;
  logic                  fault;
  logic                  misaligned;
  logic                  bad_funct3;
  logic [3:0]            size;
  logic [3:0]            size_mask;
  logic [STRB_WIDTH-1:0] strb;
  logic [XLEN-1:0]       wdata_shifted;
  logic [XLEN-1:0]       aligned_data;
  logic [2:0]            offset;
  logic [2:0]            funct3_q;

  assign accept     = lsu_valid && (mem_read || mem_write);
  assign size       = access_size(funct3);
  assign size_mask  = size - 4'd1;
  assign misaligned = (address[2:0] & size_mask[2:0]) != 3'd0;
  assign bad_funct3 = mem_write ? !(funct3 inside {F3_SB, F3_SH, F3_SW, F3_SD})
                                : !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LD,
                                                   F3_LBU, F3_LHU, F3_LWU});
  assign fault      = misaligned || bad_funct3;

  // For an 8-byte access 1 << 8 wraps to 0 in STRB_WIDTH bits, so the
  // subtraction still yields all ones.
  assign strb          = ((STRB_WIDTH'(1) << size) - STRB_WIDTH'(1)) << address[2:0];
  assign wdata_shifted = store_data << {address[2:0], 3'b000};

  load_align_extend #(.XLEN(XLEN)) u_align (
    .rdata  (bus_rdata),
    .offset (offset),
    .funct3 (funct3_q),
    .data   (aligned_data)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = fault ? RESP : BUS;
      BUS:     if (bus_ack) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      lsu_busy  <= 1'b0;
      lsu_done  <= 1'b0;
      lsu_error <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= '0;
      load_data <= '0;
      offset    <= '0;
      funct3_q  <= '0;
    end else begin
      state    <= state_next;
      lsu_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (fault) begin
              lsu_done  <= 1'b1;
              lsu_error <= 1'b1;
            end else begin
              bus_req   <= 1'b1;
              lsu_busy  <= 1'b1;
              lsu_error <= 1'b0;
              bus_we    <= mem_write;
              bus_addr  <= {address[XLEN-1:3], 3'b000};
              bus_wdata <= wdata_shifted;
              bus_wstrb <= mem_write ? strb : '0;
              offset    <= address[2:0];
              funct3_q  <= funct3;
            end
          end
        end
        BUS: begin
          if (bus_ack) begin
            bus_req  <= 1'b0;
            lsu_busy <= 1'b0;
            lsu_done <= 1'b1;
            if (!bus_we) load_data <= aligned_data;
          end
        end
        RESP:    lsu_error <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Table-driven bench for load_store_unit with a response scoreboard plus
// hand-written sequences for RESP, stray ack and mid-transfer reset.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        lsu_valid = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [63:0] address = '0;
  logic [63:0] store_data = '0;
  logic        lsu_busy, lsu_done, lsu_error;
  logic [63:0] load_data;
  logic        bus_req, bus_we;
  logic [63:0] bus_addr, bus_wdata;
  logic [7:0]  bus_wstrb;
  logic        bus_ack = 1'b0;
  logic [63:0] bus_rdata = '0;
  state_e      state;

  load_store_unit dut (
    .clock(clock), .reset(reset), .lsu_valid(lsu_valid), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .address(address), .store_data(store_data),
    .lsu_busy(lsu_busy), .lsu_done(lsu_done), .lsu_error(lsu_error), .load_data(load_data),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .state(state)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  logic [64:0] exp_q[$];  // {lsu_error, load_data} expected at each lsu_done
  logic [64:0] mon_e;
  logic [63:0] last_load = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (reset && lsu_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got lsu_done=1 expected no response at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_error", 64'(lsu_error), 64'(mon_e[64]));
        chk("resp_load_data", load_data, mon_e[63:0]);
      end
    end
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] sdata;
    logic [63:0] rdata;
    int          waits;
    logic        fault;
    logic [63:0] exp_addr;
    logic [7:0]  exp_strb;
    logic [63:0] exp_wdata;
    logic [63:0] exp_load;
  } vec_t;

  vec_t vecs[17];

  task automatic run_vec(input vec_t v);
    @(negedge clock);
    lsu_valid = 1'b1; mem_read = v.rd; mem_write = v.wr; funct3 = v.f3;
    address = v.addr; store_data = v.sdata;
    if (!v.fault && !v.wr) last_load = v.exp_load;
    exp_q.push_back({v.fault, last_load});
    @(negedge clock);
    lsu_valid = 1'b0; mem_read = 1'($urandom_range(0, 1)); mem_write = 1'b0;
    address = {$urandom, $urandom}; store_data = {$urandom, $urandom};
    if (v.fault) begin
      chk("fault_done", 64'(lsu_done), 64'd1);
      chk("fault_no_req", 64'(bus_req), 64'd0);
      chk("fault_not_busy", 64'(lsu_busy), 64'd0);
    end else begin
      chk("bus_req", 64'(bus_req), 64'd1);
      chk("busy", 64'(lsu_busy), 64'd1);
      chk("bus_we", 64'(bus_we), 64'(v.wr));
      chk("bus_addr", bus_addr, v.exp_addr);
      chk("bus_wstrb", 64'(bus_wstrb), 64'(v.exp_strb));
      if (v.wr) chk("bus_wdata", bus_wdata, v.exp_wdata);
      for (int i = 0; i < v.waits; i++) begin
        @(negedge clock);
        chk("wait_req", 64'(bus_req), 64'd1);
        chk("wait_busy", 64'(lsu_busy), 64'd1);
        chk("wait_addr", bus_addr, v.exp_addr);
        chk("wait_no_done", 64'(lsu_done), 64'd0);
      end
      bus_ack = 1'b1;
      bus_rdata = v.rdata;
      @(negedge clock);
      bus_ack = 1'b0;
      bus_rdata = {$urandom, $urandom};
      chk("done_latency", 64'(lsu_done), 64'd1);
      chk("req_dropped", 64'(bus_req), 64'd0);
      chk("resp_not_busy", 64'(lsu_busy), 64'd0);
    end
    @(negedge clock);
    chk("done_one_cycle", 64'(lsu_done), 64'd0);
    chk("back_to_idle", 64'(state), 64'(IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rd   wr   f3      addr        sdata                  rdata                  w  flt  exp_addr     strb   exp_wdata              exp_load
    vecs[0]  = '{1'b1, 1'b0, 3'b010, 64'h1004, 64'h0,                64'h8000_0001_0000_0000, 0, 1'b0, 64'h1000, 8'h00, 64'h0,                64'hFFFF_FFFF_8000_0001};
    vecs[1]  = '{1'b1, 1'b0, 3'b100, 64'h2007, 64'h0,                64'hF000_0000_0000_0000, 3, 1'b0, 64'h2000, 8'h00, 64'h0,                64'h0000_0000_0000_00F0};
    vecs[2]  = '{1'b0, 1'b1, 3'b001, 64'h3002, 64'hBEEF,             64'h0,                   1, 1'b0, 64'h3000, 8'h0C, 64'h0000_0000_BEEF_0000, 64'h0};
    vecs[3]  = '{1'b1, 1'b0, 3'b011, 64'h4004, 64'h0,                64'h0,                   0, 1'b1, 64'h0,    8'h00, 64'h0,                64'h0};
    vecs[4]  = '{1'b0, 1'b1, 3'b100, 64'h5000, 64'h1234,             64'h0,                   0, 1'b1, 64'h0,    8'h00, 64'h0,                64'h0};
    vecs[5]  = '{1'b1, 1'b0, 3'b000, 64'h6003, 64'h0,                64'h0000_0000_8000_0000, 0, 1'b0, 64'h6000, 8'h00, 64'h0,                64'hFFFF_FFFF_FFFF_FF80};
    vecs[6]  = '{1'b1, 1'b0, 3'b001, 64'h7006, 64'h0,                64'h7FFF_0000_0000_0000, 2, 1'b0, 64'h7000, 8'h00, 64'h0,                64'h0000_0000_0000_7FFF};
    vecs[7]  = '{1'b1, 1'b0, 3'b101, 64'h7006, 64'h0,                64'h8001_0000_0000_0000, 0, 1'b0, 64'h7000, 8'h00, 64'h0,                64'h0000_0000_0000_8001};
    vecs[8]  = '{1'b1, 1'b0, 3'b110, 64'h8004, 64'h0,                64'hDEAD_BEEF_0000_0000, 1, 1'b0, 64'h8000, 8'h00, 64'h0,                64'h0000_0000_DEAD_BEEF};
    vecs[9]  = '{1'b1, 1'b0, 3'b011, 64'h9000, 64'h0,                64'h0123_4567_89AB_CDEF, 1, 1'b0, 64'h9000, 8'h00, 64'h0,                64'h0123_4567_89AB_CDEF};
    vecs[10] = '{1'b0, 1'b1, 3'b011, 64'hA000, 64'h1122_3344_5566_7788, 64'h0,                0, 1'b0, 64'hA000, 8'hFF, 64'h1122_3344_5566_7788, 64'h0};
    vecs[11] = '{1'b0, 1'b1, 3'b000, 64'hB005, 64'hAB,               64'h0,                   2, 1'b0, 64'hB000, 8'h20, 64'h0000_AB00_0000_0000, 64'h0};
    vecs[12] = '{1'b0, 1'b1, 3'b010, 64'hC004, 64'hCAFE_BABE,        64'h0,                   0, 1'b0, 64'hC000, 8'hF0, 64'hCAFE_BABE_0000_0000, 64'h0};
    vecs[13] = '{1'b1, 1'b0, 3'b001, 64'hD001, 64'h0,                64'h0,                   0, 1'b1, 64'h0,    8'h00, 64'h0,                64'h0};
    vecs[14] = '{1'b1, 1'b0, 3'b111, 64'hE000, 64'h0,                64'h0,                   0, 1'b1, 64'h0,    8'h00, 64'h0,                64'h0};
    vecs[15] = '{1'b0, 1'b1, 3'b010, 64'hF002, 64'h0,                64'h0,                   0, 1'b1, 64'h0,    8'h00, 64'h0,                64'h0};
    vecs[16] = '{1'b1, 1'b1, 3'b000, 64'h1_0001, 64'h5A,             64'h0,                   1, 1'b0, 64'h1_0000, 8'h02, 64'h0000_0000_0000_5A00, 64'h0};

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_state", 64'(state), 64'(IDLE));
    chk("rst_bus_req", 64'(bus_req), 64'd0);
    chk("rst_bus_we", 64'(bus_we), 64'd0);
    chk("rst_busy", 64'(lsu_busy), 64'd0);
    chk("rst_done", 64'(lsu_done), 64'd0);
    chk("rst_error", 64'(lsu_error), 64'd0);
    chk("rst_bus_addr", bus_addr, 64'd0);
    chk("rst_bus_wdata", bus_wdata, 64'd0);
    chk("rst_bus_wstrb", 64'(bus_wstrb), 64'd0);
    chk("rst_load_data", load_data, 64'd0);
    reset = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // lsu_valid held high through RESP: only the IDLE cycles accept
    @(negedge clock);
    lsu_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b111; address = 64'h20;
    exp_q.push_back({1'b1, last_load});
    exp_q.push_back({1'b1, last_load});
    @(negedge clock);
    chk("hold_first_done", 64'(lsu_done), 64'd1);
    @(negedge clock);
    chk("hold_resp_ignored", 64'(lsu_done), 64'd0);
    chk("hold_idle", 64'(state), 64'(IDLE));
    @(negedge clock);
    lsu_valid = 1'b0; mem_read = 1'b0;
    chk("hold_second_done", 64'(lsu_done), 64'd1);
    @(negedge clock);

    // Stray ack in IDLE has no effect
    bus_ack = 1'b1;
    bus_rdata = {$urandom, $urandom};
    @(negedge clock);
    bus_ack = 1'b0;
    chk("stray_ack_state", 64'(state), 64'(IDLE));
    chk("stray_ack_done", 64'(lsu_done), 64'd0);
    chk("stray_ack_load", load_data, last_load);

    // Reset during the second BUS wait cycle of an SD
    lsu_valid = 1'b1; mem_write = 1'b1; funct3 = 3'b011; address = 64'h2_0008;
    store_data = 64'hA5A5_5A5A_0F0F_F0F0;
    @(negedge clock);
    lsu_valid = 1'b0; mem_write = 1'b0;
    chk("sd_req", 64'(bus_req), 64'd1);
    @(negedge clock);
    chk("sd_wait_req", 64'(bus_req), 64'd1);
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_req", 64'(bus_req), 64'd0);
    chk("mid_rst_state", 64'(state), 64'(IDLE));
    chk("mid_rst_done", 64'(lsu_done), 64'd0);
    chk("mid_rst_busy", 64'(lsu_busy), 64'd0);
    reset = 1'b1;
    bus_ack = 1'b1;
    @(negedge clock);
    bus_ack = 1'b0;
    chk("late_ack_state", 64'(state), 64'(IDLE));
    chk("late_ack_done", 64'(lsu_done), 64'd0);
    @(negedge clock);
    chk("late_ack_no_done", 64'(lsu_done), 64'd0);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
